// File: rtl/cs_out_fifo_pkg.sv
// Shared definitions for the CS output FIFO: state encoding and the CS result width.
package cs_out_fifo_pkg;

    // Result width of the upstream CS stage (Y[9:0]).
    localparam int CS_DW = 10;

    // Occupancy state; empty/full flags are decoded directly from it.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PART  = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/cs_fifo_ram.sv
// DEPTH x DW storage: one synchronous write port, one asynchronous read port.
module cs_fifo_ram #(
    parameter int DW    = 10,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge.
    // NOTE: storage has no reset; only pointers/count define validity, so clearing it would cost logic for nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // First-word-fall-through: the head entry is visible without a clock.
    assign rdata = mem[raddr];

endmodule

// File: rtl/cs_out_fifo.sv
// Output FIFO for CS results: FWFT, three-state occupancy tracking, saturating drop counter.
module cs_out_fifo
    import cs_out_fifo_pkg::*;
#(
    parameter int DW    = CS_DW,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          flush,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [7:0]    ovf_cnt
);

    fifo_state_t   state, state_next;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_next;
    logic          push, pop, drop;

    assign empty     = (state == ST_EMPTY);
    assign full      = (state == ST_FULL);
    assign out_valid = !empty;

    assign pop  = out_valid & out_ready;
    assign push = in_valid & (!full | pop);
    // A word offered while full with no pop is lost; flush discards everything anyway.
    assign drop = in_valid & full & !pop & !flush;

    cs_fifo_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push & !flush),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    // Next occupancy and state from push/pop; flush overrides both.
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
    always_comb begin
        state_next = state;
        count_next = count;
        if (flush) begin
            state_next = ST_EMPTY;
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + 1'b1;
            state_next = (count == CW'(DEPTH - 1)) ? ST_FULL : ST_PART;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
            state_next = (count == CW'(1)) ? ST_EMPTY : ST_PART;
        end
    end

    // State, pointers, count and drop counter registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_EMPTY;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            ovf_cnt <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                // Power-of-two depth: natural overflow of AW bits wraps modulo DEPTH.
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop && ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

endmodule
